// File: rtl/p2m_pack_indication.sv
// Receive end of the heard-indication packing path: validates 144-bit packed words,
// buffers the good payloads, and presents them as heard() calls with drop and seqno-gap counters.
module p2m_pack_indication #(
  parameter logic [15:0] METHOD_ID = 16'd3,
  parameter logic [15:0] MSG_LEN   = 16'd5,
  parameter int          DEPTH     = 2,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pipe_enq_ena_i,
  input  logic [143:0]     pipe_enq_v_i,
  output logic             pipe_enq_rdy_o,
  output logic             heard_ena_o,
  output logic [31:0]      heard_v_o,
  output logic [7:0]       heard_write_count_o,
  output logic [7:0]       heard_read_count_o,
  output logic [7:0]       heard_seqno_o,
  input  logic             heard_rdy_i,
  output logic [CNT_W-1:0] drop_count_o,
  output logic [CNT_W-1:0] seq_gap_count_o
);

  localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

  logic [55:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             exp_valid_q, exp_valid_d;
  logic [7:0]       exp_seq_q, exp_seq_d;

  logic        full, empty, good_hdr, accept, push, pop;
  logic [55:0] head;
  logic        unused_pad;

  // Payload is the contiguous slice v|writeCount|readCount|seqno at [103:48].
  assign unused_pad = ^{pipe_enq_v_i[143:128], pipe_enq_v_i[111:104], pipe_enq_v_i[47:16]};

  assign full     = (count_q == FULL_C);
  assign empty    = (count_q == '0);
  assign good_hdr = (pipe_enq_v_i[15:0] == METHOD_ID) && (pipe_enq_v_i[127:112] == MSG_LEN);
  assign accept   = pipe_enq_ena_i && !full;
  assign push     = accept && good_hdr;
  assign pop      = !empty && heard_rdy_i;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_cnt_d  = drop_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    exp_valid_d = exp_valid_q;
    exp_seq_d   = exp_seq_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (accept && !good_hdr && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;

    if (pop) begin
      if (exp_valid_q && (head[7:0] != exp_seq_q) && (gap_cnt_q != '1))
        gap_cnt_d = gap_cnt_q + 1'b1;
      exp_seq_d   = head[7:0] + 8'd1;
      exp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      exp_valid_q <= 1'b0;
      exp_seq_q   <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= pipe_enq_v_i[103:48];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      exp_valid_q <= exp_valid_d;
      exp_seq_q   <= exp_seq_d;
    end
  end

  assign pipe_enq_rdy_o      = !full;
  assign heard_ena_o         = !empty;
  assign heard_v_o           = head[55:24];
  assign heard_write_count_o = head[23:16];
  assign heard_read_count_o  = head[15:8];
  assign heard_seqno_o       = head[7:0];
  assign drop_count_o        = drop_cnt_q;
  assign seq_gap_count_o     = gap_cnt_q;

endmodule

// File: tb/tb_p2m_pack_indication.sv
// Bench for p2m_pack_indication: directed corner sequences, a vector table,
// and a randomized run against a queue-based reference model.
module tb_p2m_pack_indication;

  localparam int CNT_W = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enq_ena;
  logic [143:0]     enq_v;
  logic             enq_rdy;
  logic             h_ena;
  logic [31:0]      h_v;
  logic [7:0]       h_wc, h_rc, h_seq;
  logic             h_rdy;
  logic [CNT_W-1:0] drop_cnt, gap_cnt;

  int checks = 0;
  int errors = 0;

  p2m_pack_indication #(.METHOD_ID(16'd3), .MSG_LEN(16'd5), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .pipe_enq_ena_i      (enq_ena),
    .pipe_enq_v_i        (enq_v),
    .pipe_enq_rdy_o      (enq_rdy),
    .heard_ena_o         (h_ena),
    .heard_v_o           (h_v),
    .heard_write_count_o (h_wc),
    .heard_read_count_o  (h_rc),
    .heard_seqno_o       (h_seq),
    .heard_rdy_i         (h_rdy),
    .drop_count_o        (drop_cnt),
    .seq_gap_count_o     (gap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pad fields are randomized so the bench also shows they are ignored.
  function automatic logic [143:0] mk_word(input logic [15:0] id, input logic [15:0] len,
                                           input logic [31:0] v, input logic [7:0] wc,
                                           input logic [7:0] rc, input logic [7:0] seq);
    logic [143:0] w;
    w[31:0]    = $urandom;
    w[63:32]   = $urandom;
    w[95:64]   = $urandom;
    w[127:96]  = $urandom;
    w[143:128] = 16'($urandom);
    w[15:0]    = id;
    w[127:112] = len;
    w[103:72]  = v;
    w[71:64]   = wc;
    w[63:56]   = rc;
    w[55:48]   = seq;
    return w;
  endfunction

  typedef struct {
    logic [15:0] id;
    logic [15:0] len;
    logic [7:0]  seq;
    logic [31:0] v;
    logic        deliver;
    int          drop;
    int          gap;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mkvec(input logic [15:0] id, input logic [15:0] len, input logic [7:0] seq,
                                 input logic deliver, input int drop, input int gap);
    vec_t r;
    r.id = id; r.len = len; r.seq = seq; r.v = $urandom;
    r.deliver = deliver; r.drop = drop; r.gap = gap;
    return r;
  endfunction

  // Reference model state
  logic [55:0] mq[$];
  int          m_drop, m_gap;
  bit          m_exp_valid;
  logic [7:0]  m_exp_seq;

  initial begin
    logic [31:0]  v1, v2;
    logic [7:0]   tx_seq;
    logic [15:0]  id, len;
    logic [55:0]  hd;
    bit           m_pop, m_acc, m_good;

    tbl[0] = mkvec(16'd3, 16'd5, 8'd10,  1'b1, 0, 0);
    tbl[1] = mkvec(16'd4, 16'd5, 8'd11,  1'b0, 1, 0);
    tbl[2] = mkvec(16'd3, 16'd5, 8'd11,  1'b1, 1, 0);
    tbl[3] = mkvec(16'd3, 16'd6, 8'd12,  1'b0, 2, 0);
    tbl[4] = mkvec(16'd3, 16'd5, 8'd12,  1'b1, 2, 0);
    tbl[5] = mkvec(16'd3, 16'd5, 8'd254, 1'b1, 2, 1);
    tbl[6] = mkvec(16'd3, 16'd5, 8'd255, 1'b1, 2, 1);
    tbl[7] = mkvec(16'd3, 16'd5, 8'd0,   1'b1, 2, 1);
    tbl[8] = mkvec(16'd3, 16'd5, 8'd2,   1'b1, 2, 2);

    rst_n = 1'b0; enq_ena = 1'b0; enq_v = '0; h_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_enq_rdy", 64'(enq_rdy), 64'd1);
    chk("rst_heard_ena", 64'(h_ena), 64'd0);
    chk("rst_payload", 64'({h_v, h_wc, h_rc, h_seq}), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_gap", 64'(gap_cnt), 64'd0);
    rst_n = 1'b1;

    // Single good word, one-cycle latency, one-cycle call
    @(negedge clk);
    h_rdy = 1'b1; enq_ena = 1'b1;
    enq_v = mk_word(16'd3, 16'd5, 32'hDEADBEEF, 8'h11, 8'h22, 8'h07);
    @(negedge clk);
    enq_ena = 1'b0;
    chk("t1_ena", 64'(h_ena), 64'd1);
    chk("t1_fields", 64'({h_v, h_wc, h_rc, h_seq}), 64'({32'hDEADBEEF, 8'h11, 8'h22, 8'h07}));
    @(negedge clk);
    chk("t1_ena_off", 64'(h_ena), 64'd0);
    chk("t1_counters", 64'({drop_cnt, gap_cnt}), 64'd0);

    // Back-pressure: fill, hold off third word, then drain in order
    h_rdy = 1'b0;
    v1 = $urandom; v2 = $urandom;
    chk("t2_rdy0", 64'(enq_rdy), 64'd1);
    enq_ena = 1'b1; enq_v = mk_word(16'd3, 16'd5, v1, 8'h01, 8'h02, 8'd8);
    @(negedge clk);
    chk("t2_rdy1", 64'(enq_rdy), 64'd1);
    chk("t2_ena1", 64'(h_ena), 64'd1);
    enq_v = mk_word(16'd3, 16'd5, v2, 8'h03, 8'h04, 8'd9);
    @(negedge clk);
    chk("t2_rdy_full", 64'(enq_rdy), 64'd0);
    enq_v = mk_word(16'd3, 16'd5, 32'h0BAD_0BAD, 8'h05, 8'h06, 8'd99);
    @(negedge clk);
    chk("t2_rdy_held", 64'(enq_rdy), 64'd0);
    chk("t2_head_stable", 64'({h_v, h_seq}), 64'({v1, 8'd8}));
    enq_ena = 1'b0; h_rdy = 1'b1;
    @(negedge clk);
    chk("t2_second", 64'({h_ena, h_v, h_seq}), 64'({1'b1, v2, 8'd9}));
    chk("t2_rdy_back", 64'(enq_rdy), 64'd1);
    @(negedge clk);
    chk("t2_drained", 64'(h_ena), 64'd0);
    chk("t2_counters", 64'({drop_cnt, gap_cnt}), 64'd0);

    // Table: bad headers among good words, seqno wrap and gap
    for (int i = 0; i < 9; i++) begin
      enq_ena = 1'b1;
      enq_v = mk_word(tbl[i].id, tbl[i].len, tbl[i].v, 8'(i), 8'(i + 1), tbl[i].seq);
      @(negedge clk);
      enq_ena = 1'b0;
      chk($sformatf("tbl%0d_ena", i), 64'(h_ena), 64'(tbl[i].deliver));
      if (tbl[i].deliver)
        chk($sformatf("tbl%0d_payload", i), 64'({h_v, h_seq}), 64'({tbl[i].v, tbl[i].seq}));
      @(negedge clk);
      chk($sformatf("tbl%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].drop));
      chk($sformatf("tbl%0d_gap", i), 64'(gap_cnt), 64'(tbl[i].gap));
    end

    // Asynchronous reset with two messages buffered
    h_rdy = 1'b0; enq_ena = 1'b1;
    enq_v = mk_word(16'd3, 16'd5, 32'h1, 8'h0, 8'h0, 8'd50);
    @(negedge clk);
    enq_v = mk_word(16'd3, 16'd5, 32'h2, 8'h0, 8'h0, 8'd51);
    @(negedge clk);
    enq_ena = 1'b0;
    chk("t5_full", 64'({enq_rdy, h_ena}), 64'({1'b0, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_flags", 64'({enq_rdy, h_ena}), 64'({1'b1, 1'b0}));
    chk("t5_rst_counters", 64'({drop_cnt, gap_cnt}), 64'd0);
    chk("t5_rst_payload", 64'({h_v, h_wc, h_rc, h_seq}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    h_rdy = 1'b1; enq_ena = 1'b1;
    enq_v = mk_word(16'd3, 16'd5, 32'h77, 8'h0, 8'h0, 8'd77);
    @(negedge clk);
    enq_ena = 1'b0;
    chk("t5_after", 64'({h_ena, h_seq}), 64'({1'b1, 8'd77}));
    @(negedge clk);
    chk("t5_no_gap", 64'(gap_cnt), 64'd0);

    // Drop counter saturation
    enq_ena = 1'b1;
    for (int i = 0; i < 255; i++) begin
      enq_v = mk_word(16'd4, 16'd5, $urandom, 8'h0, 8'h0, 8'(i));
      @(negedge clk);
    end
    enq_ena = 1'b0;
    chk("t6_drop_max", 64'(drop_cnt), 64'd255);
    enq_ena = 1'b1; enq_v = mk_word(16'd3, 16'd9, 32'h0, 8'h0, 8'h0, 8'd0);
    @(negedge clk);
    enq_ena = 1'b0;
    @(negedge clk);
    chk("t6_drop_sat", 64'(drop_cnt), 64'd255);
    chk("t6_no_delivery", 64'(h_ena), 64'd0);

    // Randomized traffic against the queue model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_drop = 0; m_gap = 0; m_exp_valid = 0; m_exp_seq = '0;
    tx_seq = 8'($urandom);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      chk("rnd_enq_rdy", 64'(enq_rdy), 64'(mq.size() < DEPTH));
      chk("rnd_heard_ena", 64'(h_ena), 64'(mq.size() > 0));
      if (mq.size() > 0) chk("rnd_payload", 64'({h_v, h_wc, h_rc, h_seq}), 64'(mq[0]));
      chk("rnd_drop", 64'(drop_cnt), 64'(m_drop));
      chk("rnd_gap", 64'(gap_cnt), 64'(m_gap));

      id  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'd3;
      len = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'd5;
      if (id == 16'd3 && $urandom_range(0, 5) == 0) id = 16'd2;
      if ($urandom_range(0, 7) == 0) tx_seq = 8'($urandom);
      enq_ena = ($urandom_range(0, 2) != 0);
      enq_v   = mk_word(id, len, $urandom, 8'($urandom), 8'($urandom), tx_seq);
      h_rdy   = ($urandom_range(0, 2) != 0);

      m_pop  = (mq.size() > 0) && h_rdy;
      m_acc  = enq_ena && (mq.size() < DEPTH);
      m_good = (id == 16'd3) && (len == 16'd5);
      if (m_acc && m_good) tx_seq = tx_seq + 8'd1;
      if (m_acc && !m_good && m_drop < 255) m_drop++;
      if (m_pop) begin
        hd = mq.pop_front();
        if (m_exp_valid && hd[7:0] != m_exp_seq && m_gap < 255) m_gap++;
        m_exp_seq = hd[7:0] + 8'd1;
        m_exp_valid = 1;
      end
      if (m_acc && m_good) mq.push_back(enq_v[103:48]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
